// File: rtl/game_layer_mixer.sv
// game_layer_mixer
//   Pixel compositor sitting between the per-pixel layer generators (border,
//   moving piece, landed blocks, preview, score text) and the VGA DAC pins.
//   The highest-priority enabled layer (index 0 wins) is coloured through a
//   double-buffered palette. Writes land in a shadow bank. The shadow bank is
//   copied to the visible bank on frame_start. Layers can be made to blink,
//   paced by a frame counter. The output is a 2-stage pipeline, and the output
//   is blanked whenever the delayed ready_sig is low.
//
// Ports
//   clk          pixel clock
//   rst          asynchronous reset, active-high
//   ready_sig    active-video qualifier from the sync generator
//   frame_start  one-cycle pulse at the start of each frame (in blanking)
//   layer_en     per-pixel layer hit flags, bit i = layer i
//   blink_mask   1 = layer i is subject to blinking
//   pal_wr_en    palette write strobe (shadow bank)
//   pal_wr_addr  palette entry to write; entries >= NUM_LAYERS are ignored
//   pal_wr_data  {R,G,B} colour for the entry
//   bg_color     colour shown when no layer hits
//   red/green/blue  registered colour channels
//   pix_valid    ready_sig delayed two clocks, aligned with the colour outputs

module game_layer_mixer #(
    parameter int NUM_LAYERS   = 8,
    parameter int COLOR_W      = 4,
    parameter int BLINK_FRAMES = 32,
    localparam int AW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ready_sig,
    input  logic                    frame_start,
    input  logic [NUM_LAYERS-1:0]   layer_en,
    input  logic [NUM_LAYERS-1:0]   blink_mask,
    input  logic                    pal_wr_en,
    input  logic [AW-1:0]           pal_wr_addr,
    input  logic [3*COLOR_W-1:0]    pal_wr_data,
    input  logic [3*COLOR_W-1:0]    bg_color,
    output logic [COLOR_W-1:0]      red,
    output logic [COLOR_W-1:0]      green,
    output logic [COLOR_W-1:0]      blue,
    output logic                    pix_valid
);

    localparam int PW = 3 * COLOR_W;
    localparam int CW = $clog2(BLINK_FRAMES);
    localparam logic [CW-1:0] CNT_MAX    = CW'(BLINK_FRAMES - 1);
    localparam logic [CW-1:0] CNT_HALF   = CW'(BLINK_FRAMES / 2);
    localparam logic [AW:0]   ADDR_LIMIT = (AW + 1)'(NUM_LAYERS);

    logic [CW-1:0]         blink_cnt;
    logic [CW-1:0]         blink_cnt_next;
    logic                  blink_phase;

    logic [PW-1:0]         shadow      [NUM_LAYERS];
    logic [PW-1:0]         shadow_next [NUM_LAYERS];
    logic [PW-1:0]         active      [NUM_LAYERS];
    logic                  wr_ok;

    logic [NUM_LAYERS-1:0] eff_en;
    logic                  v1;
    logic [PW-1:0]         bg1;
    logic [PW-1:0]         pix_color;

    // Blink counter. It wraps at BLINK_FRAMES-1. The phase is registered
    // together with the count, so the phase stays constant for a whole frame.
    always_comb begin
        blink_cnt_next = (blink_cnt == CNT_MAX) ? '0 : blink_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_start) begin
            blink_cnt   <= blink_cnt_next;
            blink_phase <= (blink_cnt_next >= CNT_HALF);
        end
    end

    // The shadow bank with this cycle's write applied. The frame copy is
    // taken from this merged view, so a write in the frame_start cycle is
    // visible in the next frame. The range check guards non-power-of-two
    // layer counts.
    assign wr_ok = pal_wr_en && ({1'b0, pal_wr_addr} < ADDR_LIMIT);

    always_comb begin
        for (int i = 0; i < NUM_LAYERS; i++) begin
            shadow_next[i] = shadow[i];
            if (wr_ok && (pal_wr_addr == AW'(i))) begin
                shadow_next[i] = pal_wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                shadow[i] <= shadow_next[i];
                if (frame_start) begin
                    active[i] <= shadow_next[i];
                end
            end
        end
    end

    // Stage 1: apply blinking and capture the qualifier and the background.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eff_en <= '0;
            v1     <= 1'b0;
            bg1    <= '0;
        end else begin
            eff_en <= layer_en & ~(blink_mask & {NUM_LAYERS{blink_phase}});
            v1     <= ready_sig;
            bg1    <= bg_color;
        end
    end

    // Priority select. The loop scans from the top index down, so the lowest
    // set index is applied last and wins.
    always_comb begin
        pix_color = bg1;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (eff_en[i]) begin
                pix_color = active[i];
            end
        end
        if (!v1) begin
            pix_color = '0;
        end
    end

    // Stage 2: drive the DAC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            pix_valid <= 1'b0;
        end else begin
            red       <= pix_color[PW-1 -: COLOR_W];
            green     <= pix_color[2*COLOR_W-1 -: COLOR_W];
            blue      <= pix_color[COLOR_W-1:0];
            pix_valid <= v1;
        end
    end

endmodule

// File: tb/tb_game_layer_mixer.sv
// tb_game_layer_mixer
//   Directed bench for game_layer_mixer. The DUT is configured with 5 layers
//   (a non-power-of-two count, so the address range check matters) and a
//   4-frame blink period. Inputs change 1 time unit after a rising edge.
//   Outputs are inspected 1 time unit after the edge that produces them.

module tb_game_layer_mixer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready_sig;
    logic        frame_start;
    logic [4:0]  layer_en;
    logic [4:0]  blink_mask;
    logic        pal_wr_en;
    logic [2:0]  pal_wr_addr;
    logic [11:0] pal_wr_data;
    logic [11:0] bg_color;
    logic [3:0]  red;
    logic [3:0]  green;
    logic [3:0]  blue;
    logic        pix_valid;

    int total = 0;
    int bad   = 0;

    game_layer_mixer #(
        .NUM_LAYERS   (5),
        .COLOR_W      (4),
        .BLINK_FRAMES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ready_sig   (ready_sig),
        .frame_start (frame_start),
        .layer_en    (layer_en),
        .blink_mask  (blink_mask),
        .pal_wr_en   (pal_wr_en),
        .pal_wr_addr (pal_wr_addr),
        .pal_wr_data (pal_wr_data),
        .bg_color    (bg_color),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .pix_valid   (pix_valid)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_pal(input logic [2:0] addr, input logic [11:0] data);
        pal_wr_en   = 1'b1;
        pal_wr_addr = addr;
        pal_wr_data = data;
        tick();
        pal_wr_en   = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if ({red, green, blue, pix_valid} !== 13'h0) begin
            bad++;
            $display("[TB] FAIL reset_hold: got rgb=%h valid=%b, expected rgb=000 valid=0", {red, green, blue}, pix_valid);
        end
        rst       = 1'b0;
        ready_sig = 1'b1;
        bg_color  = 12'h00A;
        layer_en  = 5'b00000;
        tick();
        tick();
        total++;
        if ({red, green, blue, pix_valid} !== {12'h00A, 1'b1}) begin
            bad++;
            $display("[TB] FAIL pre_reset_bg: got rgb=%h valid=%b, expected rgb=00a valid=1", {red, green, blue}, pix_valid);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({red, green, blue, pix_valid} !== 13'h0) begin
            bad++;
            $display("[TB] FAIL reset_async: got rgb=%h valid=%b, expected rgb=000 valid=0", {red, green, blue}, pix_valid);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        total++;
        if ({red, green, blue, pix_valid} !== 13'h0) begin
            bad++;
            $display("[TB] FAIL post_release_1: got rgb=%h valid=%b, expected rgb=000 valid=0", {red, green, blue}, pix_valid);
        end
        tick();
        total++;
        if ({red, green, blue, pix_valid} !== {12'h00A, 1'b1}) begin
            bad++;
            $display("[TB] FAIL post_release_2: got rgb=%h valid=%b, expected rgb=00a valid=1", {red, green, blue}, pix_valid);
        end
    endtask

    task automatic test_priority();
        write_pal(3'd0, 12'hF00);
        write_pal(3'd3, 12'h0F0);
        pulse_frame();
        ready_sig = 1'b1;
        layer_en  = 5'b01001;
        tick();
        tick();
        total++;
        if ({red, green, blue, pix_valid} !== {12'hF00, 1'b1}) begin
            bad++;
            $display("[TB] FAIL prio_l0: got rgb=%h valid=%b, expected rgb=f00 valid=1", {red, green, blue}, pix_valid);
        end
        layer_en = 5'b01000;
        tick();
        tick();
        total++;
        if ({red, green, blue, pix_valid} !== {12'h0F0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL prio_l3: got rgb=%h valid=%b, expected rgb=0f0 valid=1", {red, green, blue}, pix_valid);
        end
        layer_en = 5'b00000;
        bg_color = 12'h00A;
        tick();
        tick();
        total++;
        if ({red, green, blue, pix_valid} !== {12'h00A, 1'b1}) begin
            bad++;
            $display("[TB] FAIL prio_bg: got rgb=%h valid=%b, expected rgb=00a valid=1", {red, green, blue}, pix_valid);
        end
    endtask

    task automatic test_back_to_back();
        layer_en = 5'b01001;
        tick();
        layer_en = 5'b01000;
        tick();
        total++;
        if ({red, green, blue} !== 12'hF00) begin
            bad++;
            $display("[TB] FAIL b2b_0: got rgb=%h, expected rgb=f00", {red, green, blue});
        end
        layer_en = 5'b00000;
        bg_color = 12'h005;
        tick();
        total++;
        if ({red, green, blue} !== 12'h0F0) begin
            bad++;
            $display("[TB] FAIL b2b_1: got rgb=%h, expected rgb=0f0", {red, green, blue});
        end
        tick();
        total++;
        if ({red, green, blue} !== 12'h005) begin
            bad++;
            $display("[TB] FAIL b2b_2: got rgb=%h, expected rgb=005", {red, green, blue});
        end
    endtask

    task automatic test_shadow();
        bg_color = 12'h00A;
        layer_en = 5'b00100;
        write_pal(3'd2, 12'hFFF);
        tick();
        tick();
        total++;
        if ({red, green, blue} !== 12'h000) begin
            bad++;
            $display("[TB] FAIL shadow_hidden: got rgb=%h, expected rgb=000", {red, green, blue});
        end
        pulse_frame();
        tick();
        tick();
        total++;
        if ({red, green, blue} !== 12'hFFF) begin
            bad++;
            $display("[TB] FAIL shadow_swap: got rgb=%h, expected rgb=fff", {red, green, blue});
        end
        pal_wr_en   = 1'b1;
        pal_wr_addr = 3'd1;
        pal_wr_data = 12'h123;
        frame_start = 1'b1;
        layer_en    = 5'b00010;
        tick();
        pal_wr_en   = 1'b0;
        frame_start = 1'b0;
        tick();
        tick();
        total++;
        if ({red, green, blue} !== 12'h123) begin
            bad++;
            $display("[TB] FAIL shadow_same_cycle: got rgb=%h, expected rgb=123", {red, green, blue});
        end
        write_pal(3'd4, 12'h111);
        write_pal(3'd4, 12'h222);
        pulse_frame();
        layer_en = 5'b10000;
        tick();
        tick();
        total++;
        if ({red, green, blue} !== 12'h222) begin
            bad++;
            $display("[TB] FAIL shadow_last_wins: got rgb=%h, expected rgb=222", {red, green, blue});
        end
    endtask

    task automatic test_blanking();
        ready_sig = 1'b0;
        layer_en  = 5'b11111;
        tick();
        tick();
        total++;
        if ({red, green, blue, pix_valid} !== 13'h0) begin
            bad++;
            $display("[TB] FAIL blanking: got rgb=%h valid=%b, expected rgb=000 valid=0", {red, green, blue}, pix_valid);
        end
        ready_sig = 1'b1;
    endtask

    task automatic test_bad_addr();
        logic [11:0] exp_pal [5];
        exp_pal[0] = 12'hF00;
        exp_pal[1] = 12'h123;
        exp_pal[2] = 12'hFFF;
        exp_pal[3] = 12'h0F0;
        exp_pal[4] = 12'h222;
        for (int a = 5; a < 8; a++) begin
            write_pal(3'(a), 12'hABC);
        end
        pulse_frame();
        for (int i = 0; i < 5; i++) begin
            layer_en = 5'(1 << i);
            tick();
            tick();
            total++;
            if ({red, green, blue} !== exp_pal[i]) begin
                bad++;
                $display("[TB] FAIL bad_addr_entry%0d: got rgb=%h, expected rgb=%h", i, {red, green, blue}, exp_pal[i]);
            end
        end
    endtask

    task automatic test_blink();
        logic [11:0] exp_rgb;
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        ready_sig  = 1'b1;
        bg_color   = 12'h00A;
        blink_mask = 5'b00010;
        layer_en   = 5'b00010;
        tick();
        tick();
        total++;
        if ({red, green, blue} !== 12'h000) begin
            bad++;
            $display("[TB] FAIL blink_frame0: got rgb=%h, expected rgb=000", {red, green, blue});
        end
        pal_wr_en   = 1'b1;
        pal_wr_addr = 3'd1;
        pal_wr_data = 12'h5A3;
        frame_start = 1'b1;
        tick();
        pal_wr_en   = 1'b0;
        frame_start = 1'b0;
        tick();
        tick();
        total++;
        if ({red, green, blue} !== 12'h5A3) begin
            bad++;
            $display("[TB] FAIL blink_frame1: got rgb=%h, expected rgb=5a3", {red, green, blue});
        end
        for (int k = 2; k < 6; k++) begin
            pulse_frame();
            tick();
            tick();
            exp_rgb = ((k % 4) >= 2) ? 12'h00A : 12'h5A3;
            total++;
            if ({red, green, blue} !== exp_rgb) begin
                bad++;
                $display("[TB] FAIL blink_frame%0d: got rgb=%h, expected rgb=%h", k, {red, green, blue}, exp_rgb);
            end
        end
        blink_mask = 5'b00000;
    endtask

    initial begin
        rst         = 1'b1;
        ready_sig   = 1'b0;
        frame_start = 1'b0;
        layer_en    = 5'b00000;
        blink_mask  = 5'b00000;
        pal_wr_en   = 1'b0;
        pal_wr_addr = 3'd0;
        pal_wr_data = 12'h000;
        bg_color    = 12'h000;
        test_reset();
        test_priority();
        test_back_to_back();
        test_shadow();
        test_blanking();
        test_bad_addr();
        test_blink();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
